// File: rtl/dbg_guv_log_arb.sv
// Round-robin, packet-aware arbiter merging the catted log streams of several
// debug governors onto one registered AXI-Stream log channel tagged with source index.
module dbg_guv_log_arb #(
    parameter int unsigned N_INPUTS   = 4,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 69,
    parameter bit          PKT_LOCK   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_TDATA,
    input  logic [N_INPUTS-1:0]            in_TVALID,
    output logic [N_INPUTS-1:0]            in_TREADY,
    input  logic [N_INPUTS-1:0]            in_TLAST,
    output logic [DATA_WIDTH-1:0]          out_TDATA,
    output logic                           out_TVALID,
    input  logic                           out_TREADY,
    output logic                           out_TLAST,
    output logic [SEL_WIDTH-1:0]           out_TID
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] grant;
    logic [SEL_WIDTH-1:0] last_grant;
    logic [SEL_WIDTH-1:0] next_grant;
    logic                 any_valid;
    logic                 grant_ready;
    logic                 take;
    logic                 release_grant;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        next_grant = '0;
        any_valid  = 1'b0;
        for (int unsigned k = 1; k <= N_INPUTS; k++) begin
            idx = (32'(last_grant) + k) % N_INPUTS;
            if (!any_valid && in_TVALID[idx]) begin
                any_valid  = 1'b1;
                next_grant = SEL_WIDTH'(idx);
            end
        end
    end

    assign grant_ready   = !out_TVALID || out_TREADY;
    assign take          = (state == LOCKED) && in_TVALID[grant] && grant_ready;
    assign release_grant = take && (!PKT_LOCK || in_TLAST[grant]);

    always_comb begin
        in_TREADY = '0;
        if (state == LOCKED)
            in_TREADY[grant] = grant_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SEL_WIDTH'(N_INPUTS - 1);
            out_TDATA  <= '0;
            out_TVALID <= 1'b0;
            out_TLAST  <= 1'b0;
            out_TID    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= next_grant;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (release_grant) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register drains independently of the grant state.
            if (take) begin
                out_TDATA  <= in_TDATA[grant*DATA_WIDTH +: DATA_WIDTH];
                out_TLAST  <= in_TLAST[grant];
                out_TID    <= grant;
                out_TVALID <= 1'b1;
            end else if (out_TREADY) begin
                out_TVALID <= 1'b0;
            end
        end
    end

endmodule
